// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and default width shared by the serial adder files
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_fulladder.sv
// fulladder: one-bit full adder cell
// Ports: A, B, Cin - operand and carry-in bits; S - sum bit; Cout - carry-out bit
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock through a single full adder cell
// Ports: CLK clock; RST async active-high reset; Start request (ignored while Busy);
//        A/B/Cin operands latched on accepted Start; Busy high in RUN; Done one-cycle
//        completion pulse; S/Cout registered result, updated only on completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_shs;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic             w_load;

    fulladder fa0 (
        .A   (r_sha[0]),
        .B   (r_shb[0]),
        .Cin (r_carry),
        .S   (w_sum),
        .Cout(w_cout)
    );

    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign w_load = (r_state != RUN) && Start;

    always_comb begin
        w_next = IDLE;
        if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else
            w_next = Start ? RUN : IDLE;
    end

    always_comb begin
        Busy = r_state == RUN;
        Done = r_state == DONE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_sha   <= '0;
            r_shb   <= '0;
            r_shs   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_sha   <= A;
                r_shb   <= B;
                r_carry <= Cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_sha   <= r_sha >> 1;
                r_shb   <= r_shb >> 1;
                r_shs   <= {w_sum, r_shs[WIDTH-1:1]};
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CW'(1);
                // the final sum bit is merged directly so S never shows a partial value
                if (w_last) begin
                    S    <= {w_sum, r_shs[WIDTH-1:1]};
                    Cout <= w_cout;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder with directed vectors and a short sweep
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       cout;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[$];
    logic [8:0] last = '0;
    logic       prev_done = 1'b0;

    serial_adder #(.WIDTH(8)) dut (
        .CLK  (clk),
        .RST  (rst),
        .Start(start),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .Busy (busy),
        .Done (done),
        .S    (s),
        .Cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // monitor: pops the scoreboard on every Done, otherwise requires the result to hold
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            last      = '0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (prev_done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_width got=2-cycle expected=1-cycle at %0t", $time);
                end
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got=%h expected=none at %0t", {cout, s}, $time);
                end else
                    check("result", 32'({cout, s}), 32'(q.pop_front()));
                last = {cout, s};
            end else
                check("hold", 32'({cout, s}), 32'(last));
            prev_done = done;
        end
    end

    task automatic start_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        q.push_back(9'(ta) + 9'(tb) + 9'(tc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 0;
        busy_n = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout got=no_done expected=done at %0t", $time);
        end
        check("busy_at_done", 32'(busy), 32'(0));
    endtask

    initial begin
        int cyc, bn, n;
        #1;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_result", 32'({cout, s}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        start_add(8'h5A, 8'h3C, 1'b0);
        wait_done(cyc, bn);
        check("latency", 32'(cyc), 32'(8));
        check("busy_cycles", 32'(bn), 32'(8));
        check("sum_5a_3c", 32'({cout, s}), 32'(9'h096));

        start_add(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bn);
        check("sum_ff_01", 32'({cout, s}), 32'(9'h100));
        start_add(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc, bn);
        check("sum_ff_ff_1", 32'({cout, s}), 32'(9'h1FF));
        start_add(8'h80, 8'h80, 1'b0);
        wait_done(cyc, bn);
        start_add(8'h00, 8'h00, 1'b1);
        wait_done(cyc, bn);

        start_add(8'h12, 8'h34, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bn);
        check("ignored_start_latency", 32'(cyc + 4), 32'(8));
        check("sum_12_34_1", 32'({cout, s}), 32'(9'h047));
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("no_second_done", 32'(n), 32'(0));

        start_add(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        q.delete();
        #1;
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_done", 32'(done), 32'(0));
        check("async_rst_result", 32'({cout, s}), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        start_add(8'h01, 8'h01, 1'b0);
        wait_done(cyc, bn);
        check("sum_01_01", 32'({cout, s}), 32'(9'h002));

        start_add(8'h33, 8'h44, 1'b0);
        wait_done(cyc, bn);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        q.push_back(9'h030);
        @(negedge clk);
        start = 1'b0;
        check("first_result_held", 32'({cout, s}), 32'(9'h077));
        wait_done(cyc, bn);
        check("back_to_back_gap", 32'(cyc + 1), 32'(9));
        check("sum_10_20", 32'({cout, s}), 32'(9'h030));

        for (int i = 0; i < 200; i++) begin
            start_add(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done(cyc, bn);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
